score_controller: RTL and testbench

Sequences the 6-digit BCD race score shown by the on-screen scoreboard.
- Game-state FSM gates the distance prescaler, so points accrue only while racing.
- Arbitrates the distance tick and two bonus requesters onto one serial BCD adder.
- Exposes the committed score and a blanking enable to the scoreboard renderer.

---
 rtl/score_pkg.sv | 33 +++
 rtl/bcd_digit_add.sv | 18 +
 rtl/score_controller.sv | 177 +++++++++++++++++
 tb/tb_score_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared encodings and BCD addend constants for the race score controller.
package score_pkg;

  localparam int unsigned DIGITS_DEF = 6;
  localparam int unsigned ADDEND_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CRASH = 3'd2,
    ST_OVER  = 3'd3
  } game_state_e;

  typedef enum logic [1:0] {
    SRC_TICK = 2'd0,
    SRC_CAR  = 2'd1,
    SRC_FUEL = 2'd2
  } add_src_e;

  localparam logic [ADDEND_W-1:0] ADD_TICK = 16'h0001;
  localparam logic [ADDEND_W-1:0] ADD_CAR  = 16'h0050;
  localparam logic [ADDEND_W-1:0] ADD_FUEL = 16'h1000;

  // BCD addend for a granted source.
  function automatic logic [ADDEND_W-1:0] addend_of(input add_src_e src);
    case (src)
      SRC_CAR:  addend_of = ADD_CAR;
      SRC_FUEL: addend_of = ADD_FUEL;
      default:  addend_of = ADD_TICK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit of the serial score adder: s = a + b + cin with decimal carry.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = 5'(a) + 5'(b) + 5'(cin);
    cout = (raw > 5'd9);
    s    = cout ? 4'(raw - 5'd10) : raw[3:0];
  end

endmodule

// File: rtl/score_controller.sv
// Race score sequencer: game FSM, distance prescaler, tick/bonus arbitration
// and a digit-serial BCD adder that commits the score atomically.
module score_controller
  import score_pkg::*;
#(
  parameter int unsigned DIGITS       = DIGITS_DEF,
  parameter int unsigned TICK_DIV     = 25000000,
  parameter int unsigned CRASH_CYCLES = 50000000,
  parameter int unsigned BLINK_DIV    = 12500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                crash,
  input  logic                fuel_empty,
  input  logic [1:0]          bonus_req,
  output logic [1:0]          bonus_ack,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [2:0]          game_state,
  output logic                display_en,
  output logic                overflow
);

  localparam int unsigned SCORE_W = 4 * DIGITS;
  localparam int unsigned IDX_W   = $clog2(DIGITS + 1);
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CRASH_W = (CRASH_CYCLES > 1) ? $clog2(CRASH_CYCLES) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCORE_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  game_state_e          state, state_nxt;
  logic [PRESC_W-1:0]   presc;
  logic [CRASH_W-1:0]   crash_cnt;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 tick_pending, rr_ptr;
  logic                 busy, carry;
  logic [IDX_W-1:0]     dig_idx;
  logic [SCORE_W-1:0]   shadow, addend;
  logic                 run_entry, wrap, tick_req, grant, stay_crash;
  logic [1:0]           bonus_win;
  add_src_e             grant_src;
  logic [3:0]           dig_a, dig_b, dig_s;
  logic                 dig_cout;

  assign game_state = state;

  // Game state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; fuel_empty outranks crash and the crash timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (fuel_empty)  state_nxt = ST_OVER;
        else if (crash)  state_nxt = ST_CRASH;
      end
      ST_CRASH: begin
        if (fuel_empty) state_nxt = ST_OVER;
        else if (crash_cnt == CRASH_W'(CRASH_CYCLES - 1)) state_nxt = ST_RUN;
      end
      ST_OVER:  if (start) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Arbitration: a tick (pending or wrapping now) beats bonuses; bonuses only in RUN.
  always_comb begin
    run_entry  = (state == ST_IDLE) && (state_nxt == ST_RUN);
    stay_crash = (state == ST_CRASH) && (state_nxt == ST_CRASH);
    wrap       = (state == ST_RUN) && (presc == PRESC_W'(TICK_DIV - 1));
    tick_req   = tick_pending | wrap;
    bonus_win  = 2'b00;
    if (!busy && !tick_req && (state == ST_RUN)) begin
      if (bonus_req == 2'b11) bonus_win = rr_ptr ? 2'b10 : 2'b01;
      else                    bonus_win = bonus_req;
    end
    grant     = !busy && (tick_req || (bonus_win != 2'b00));
    grant_src = tick_req ? SRC_TICK : (bonus_win[1] ? SRC_FUEL : SRC_CAR);
  end

  // Select the digit currently being summed.
  always_comb begin
    dig_a = 4'h0;
    dig_b = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx == IDX_W'(i)) begin
        dig_a = shadow[4*i +: 4];
        dig_b = addend[4*i +: 4];
      end
    end
  end

  bcd_digit_add u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .s    (dig_s),
    .cout (dig_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      presc        <= '0;
      crash_cnt    <= '0;
      blink_cnt    <= '0;
      tick_pending <= 1'b0;
      rr_ptr       <= 1'b0;
      busy         <= 1'b0;
      carry        <= 1'b0;
      dig_idx      <= '0;
      shadow       <= '0;
      addend       <= '0;
      bonus_ack    <= 2'b00;
      score_bcd    <= '0;
      display_en   <= 1'b1;
      overflow     <= 1'b0;
    end else begin
      bonus_ack <= bonus_win;
      if (bonus_win != 2'b00) rr_ptr <= ~bonus_win[1];

      if (run_entry)            presc <= '0;
      else if (state == ST_RUN) presc <= wrap ? '0 : presc + 1'b1;

      // An idle adder consumes the tick this cycle; a busy one parks it.
      tick_pending <= busy & tick_req;

      crash_cnt <= stay_crash ? crash_cnt + 1'b1 : '0;
      if (stay_crash) begin
        if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
          blink_cnt  <= '0;
          display_en <= ~display_en;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt  <= '0;
        display_en <= 1'b1;
      end

      // Load, DIGITS digit steps LSD first, then commit.
      if (!busy) begin
        if (grant) begin
          busy    <= 1'b1;
          dig_idx <= '0;
          carry   <= 1'b0;
          shadow  <= score_bcd;
          addend  <= SCORE_W'(addend_of(grant_src));
        end
      end else if (dig_idx == IDX_W'(DIGITS)) begin
        busy <= 1'b0;
        if (carry) begin
          score_bcd <= ALL_NINES;
          overflow  <= 1'b1;
        end else begin
          score_bcd <= shadow;
        end
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (dig_idx == IDX_W'(i)) shadow[4*i +: 4] <= dig_s;
        end
        carry   <= dig_cout;
        dig_idx <= dig_idx + 1'b1;
      end

      if (run_entry) begin
        score_bcd <= '0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller; edge numbers count from the start edge (edge 1).
// TICK_DIV is 16 so one 8-cycle add always finishes before the next tick wraps.
module tb_score_controller;

  localparam int unsigned DIGITS       = 6;
  localparam int unsigned TICK_DIV     = 16;
  localparam int unsigned CRASH_CYCLES = 8;
  localparam int unsigned BLINK_DIV    = 2;

  logic                clk;
  logic                reset;
  logic                start;
  logic                crash;
  logic                fuel_empty;
  logic [1:0]          bonus_req;
  logic [1:0]          bonus_ack;
  logic [4*DIGITS-1:0] score_bcd;
  logic [2:0]          game_state;
  logic                display_en;
  logic                overflow;

  int n_cmp;
  int n_bad;
  int now;

  score_controller #(
    .DIGITS       (DIGITS),
    .TICK_DIV     (TICK_DIV),
    .CRASH_CYCLES (CRASH_CYCLES),
    .BLINK_DIV    (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .crash      (crash),
    .fuel_empty (fuel_empty),
    .bonus_req  (bonus_req),
    .bonus_ack  (bonus_ack),
    .score_bcd  (score_bcd),
    .game_state (game_state),
    .display_en (display_en),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after edge n.
  task automatic to_edge(input int n);
    while (now < n) begin
      @(posedge clk);
      now++;
    end
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    now   = 0;
    reset = 1'b1;
    start = 1'b0;
    crash = 1'b0;
    fuel_empty = 1'b0;
    bonus_req  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_ack", 32'(bonus_ack), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_disp", 32'(display_en), 32'd1);

    // Start race; ticks wrap at 17+16n and commit 7 edges later.
    reset = 1'b0;
    start = 1'b1;
    to_edge(1);
    start = 1'b0;
    check("start_run", 32'(game_state), 32'd1);
    to_edge(23);  check("tick1_pre", 32'(score_bcd), 32'h0);
    to_edge(24);  check("tick1", 32'(score_bcd), 32'h1);
    to_edge(40);  check("tick2", 32'(score_bcd), 32'h2);

    // Both bonuses held: round-robin, ticks take priority at 49 and 65.
    bonus_req = 2'b11;
    to_edge(41);  check("ack_car", 32'(bonus_ack), 32'h1);
    to_edge(42);  check("ack_pulse", 32'(bonus_ack), 32'h0);
    to_edge(48);  check("add_car", 32'(score_bcd), 32'h52);
    to_edge(49);  check("tick_wins", 32'(bonus_ack), 32'h0);
    to_edge(56);  check("tick3", 32'(score_bcd), 32'h53);
    to_edge(57);  check("ack_fuel", 32'(bonus_ack), 32'h2);
    to_edge(64);  check("add_fuel", 32'(score_bcd), 32'h1053);
    to_edge(72);  check("tick4", 32'(score_bcd), 32'h1054);
    to_edge(73);  check("ack_car2", 32'(bonus_ack), 32'h1);
    bonus_req = 2'b00;
    to_edge(80);  check("add_car2", 32'(score_bcd), 32'h1104);
    to_edge(88);  check("tick5", 32'(score_bcd), 32'h1105);

    // Crash at edge 91: 8 cycles, blink every 2, prescaler frozen at 10.
    to_edge(90);
    crash = 1'b1;
    to_edge(91);
    crash = 1'b0;
    check("crash_state", 32'(game_state), 32'd2);
    check("crash_disp0", 32'(display_en), 32'd1);
    to_edge(93);  check("crash_disp2", 32'(display_en), 32'd0);
    to_edge(95);  check("crash_disp4", 32'(display_en), 32'd1);
    to_edge(98);  check("crash_last", 32'(game_state), 32'd2);
    check("crash_disp7", 32'(display_en), 32'd0);
    to_edge(99);  check("crash_exit", 32'(game_state), 32'd1);
    check("crash_exit_disp", 32'(display_en), 32'd1);
    to_edge(104); check("presc_frozen", 32'(score_bcd), 32'h1105);
    to_edge(111); check("tick6_pre", 32'(score_bcd), 32'h1105);
    to_edge(112); check("tick6", 32'(score_bcd), 32'h1106);

    // fuel_empty while the tick granted at 121 is in flight.
    to_edge(123);
    fuel_empty = 1'b1;
    to_edge(124);
    fuel_empty = 1'b0;
    bonus_req  = 2'b01;
    check("over_state", 32'(game_state), 32'd3);
    to_edge(127); check("over_inflight_pre", 32'(score_bcd), 32'h1106);
    to_edge(128); check("over_commit", 32'(score_bcd), 32'h1107);
    to_edge(129); check("over_no_ack", 32'(bonus_ack), 32'h0);
    to_edge(130); check("over_no_ack2", 32'(bonus_ack), 32'h0);
    bonus_req = 2'b00;
    start = 1'b1;
    to_edge(131);
    start = 1'b0;
    check("idle_state", 32'(game_state), 32'd0);
    check("idle_hold", 32'(score_bcd), 32'h1107);
    to_edge(132);
    start = 1'b1;
    to_edge(133);
    start = 1'b0;
    check("restart_state", 32'(game_state), 32'd1);
    check("restart_clear", 32'(score_bcd), 32'h0);

    // Saturation: preload 999998, add 1000, then a tick on all-9s.
    to_edge(134);
    force dut.score_bcd = 24'h999998;
    to_edge(135);
    release dut.score_bcd;
    bonus_req = 2'b10;
    to_edge(136);
    bonus_req = 2'b00;
    check("sat_ack", 32'(bonus_ack), 32'h2);
    to_edge(142); check("sat_pre", 32'(score_bcd), 32'h999998);
    check("sat_pre_ovf", 32'(overflow), 32'd0);
    to_edge(143); check("sat_score", 32'(score_bcd), 32'h999999);
    check("sat_ovf", 32'(overflow), 32'd1);
    to_edge(156); check("sat_tick", 32'(score_bcd), 32'h999999);
    check("sat_tick_ovf", 32'(overflow), 32'd1);

    // Reset three cycles into the tick add granted at 165.
    to_edge(167);
    reset = 1'b1;
    to_edge(168);
    reset = 1'b0;
    check("midrst_score", 32'(score_bcd), 32'h0);
    check("midrst_ack", 32'(bonus_ack), 32'h0);
    check("midrst_state", 32'(game_state), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_disp", 32'(display_en), 32'd1);
    to_edge(176); check("midrst_nocommit", 32'(score_bcd), 32'h0);
    check("midrst_idle", 32'(game_state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
